// File: rtl/oflow_score_board_kway.sv
`timescale 1ns/1ps
`default_nettype none
//----------------------------------------------------------------------------
// oflow_score_board_kway - per-row K-candidate score board with pointer/override | rev 1.0
//----------------------------------------------------------------------------
module oflow_score_board_kway #(
   parameter  int ROWS    = 32,
   parameter  int K       = 4,
   parameter  int SCORE_W = 16,
   parameter  int ID_W    = 12,
   localparam int PW      = (K > 1) ? $clog2(K) : 1,
   localparam int RW      = $clog2(ROWS)
) (
   input  logic                    clk,
   input  logic                    reset_N,
   input  logic                    ready_new_frame,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [RW-1:0]           wr_row,
   input  logic [K*SCORE_W-1:0]    wr_scores,
   input  logic [K*ID_W-1:0]       wr_ids,
   output logic                    done_score_board,
   input  logic [RW-1:0]           cr_row,
   output logic [SCORE_W-1:0]      score_to_cr,
   output logic [ID_W-1:0]         id_to_cr,
   output logic [PW-1:0]           ptr_to_cr,
   output logic                    exhausted_to_cr,
   input  logic                    adv_valid,
   input  logic [RW-1:0]           adv_row,
   input  logic                    ovr_valid,
   input  logic [RW-1:0]           ovr_row,
   input  logic [ID_W-1:0]         ovr_id,
   input  logic [RW-1:0]           rd_row,
   output logic [ID_W-1:0]         id_to_buffer,
   output logic [ROWS*ID_W-1:0]    id_out,
   output logic [ROWS-1:0]         row_valid,
   output logic [RW:0]             rows_written,
   output logic                    err_row
);

   localparam logic [PW-1:0] c_ptr_last = PW'(K - 1);
   localparam logic [RW:0]   c_rows     = (RW + 1)'(ROWS);

   logic                 w_wr_fire;
   logic                 w_wr_in;
   logic                 w_adv_in;
   logic                 w_ovr_in;
   logic                 w_oob;

   logic [ROWS-1:0]      w_valid;
   logic [ROWS-1:0]      w_exh;
   logic [ROWS-1:0]      w_wr_new;
   logic [PW-1:0]        w_ptr       [ROWS];
   logic [SCORE_W-1:0]   w_cur_score [ROWS];
   logic [ID_W-1:0]      w_cur_id    [ROWS];

   logic                 r_done;
   logic [RW:0]          r_rows_written;
   logic                 r_err;

   assign wr_ready  = ~ready_new_frame;
   assign w_wr_fire = wr_valid & wr_ready;
   assign w_wr_in   = {1'b0, wr_row}  < c_rows;
   assign w_adv_in  = {1'b0, adv_row} < c_rows;
   assign w_ovr_in  = {1'b0, ovr_row} < c_rows;

   // Out-of-range indices never match a row below, so they fall through as no-ops.
   assign w_oob = (w_wr_fire & ~w_wr_in) | (adv_valid & ~w_adv_in) | (ovr_valid & ~w_ovr_in);

   for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      logic [SCORE_W-1:0] r_score [K];
      logic [ID_W-1:0]    r_id    [K];
      logic [PW-1:0]      r_ptr;
      logic               r_valid;
      logic               r_exh;
      logic               w_sel_wr;
      logic               w_sel_adv;
      logic               w_sel_ovr;

      assign w_sel_wr  = w_wr_fire & (wr_row == RW'(gi));
      assign w_sel_adv = adv_valid & (adv_row == RW'(gi)) & r_valid & ~w_sel_wr;
      assign w_sel_ovr = ovr_valid & (ovr_row == RW'(gi)) & r_valid & ~w_sel_wr;

      always_ff @(posedge clk or negedge reset_N) begin
         if (!reset_N) begin
            for (int s = 0; s < K; s++) begin
               r_score[s] <= '0;
               r_id[s]    <= '0;
            end
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_exh   <= 1'b0;
         end else if (ready_new_frame) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_exh   <= 1'b0;
         end else if (w_sel_wr) begin
            for (int s = 0; s < K; s++) begin
               r_score[s] <= wr_scores[s*SCORE_W +: SCORE_W];
               r_id[s]    <= wr_ids[s*ID_W +: ID_W];
            end
            r_ptr   <= '0;
            r_valid <= 1'b1;
            r_exh   <= 1'b0;
         end else begin
            // Override targets the slot the pointer held before any same-cycle advance.
            if (w_sel_ovr) begin
               r_id[r_ptr] <= ovr_id;
            end
            if (w_sel_adv) begin
               if (r_ptr == c_ptr_last) begin
                  r_exh <= 1'b1;
               end else begin
                  r_ptr <= r_ptr + 1'b1;
               end
            end
         end
      end

      assign w_valid[gi]     = r_valid;
      assign w_exh[gi]       = r_valid & r_exh;
      assign w_ptr[gi]       = r_valid ? r_ptr : '0;
      assign w_cur_score[gi] = r_valid ? r_score[r_ptr] : '0;
      assign w_cur_id[gi]    = r_valid ? r_id[r_ptr] : '0;
      assign w_wr_new[gi]    = w_sel_wr & ~r_valid;
      assign id_out[gi*ID_W +: ID_W] = w_cur_id[gi];
   end

   always_comb begin
      score_to_cr     = '0;
      id_to_cr        = '0;
      ptr_to_cr       = '0;
      exhausted_to_cr = 1'b0;
      id_to_buffer    = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (cr_row == RW'(i)) begin
            score_to_cr     = w_cur_score[i];
            id_to_cr        = w_cur_id[i];
            ptr_to_cr       = w_ptr[i];
            exhausted_to_cr = w_exh[i];
         end
         if (rd_row == RW'(i)) begin
            id_to_buffer = w_cur_id[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_N) begin
      if (!reset_N) begin
         r_done         <= 1'b0;
         r_rows_written <= '0;
         r_err          <= 1'b0;
      end else if (ready_new_frame) begin
         r_done         <= 1'b0;
         r_rows_written <= '0;
         r_err          <= 1'b0;
      end else begin
         r_done <= w_wr_fire & w_wr_in;
         if (|w_wr_new) begin
            r_rows_written <= r_rows_written + 1'b1;
         end
         r_err <= r_err | w_oob;
      end
   end

   assign done_score_board = r_done;
   assign rows_written     = r_rows_written;
   assign err_row          = r_err;
   assign row_valid        = w_valid;

endmodule

`default_nettype wire
